// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Multiplies use an iterative shift-add engine that takes one multiplier bit per cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | in_ready=1; wait for a request and capture it
// MUL    | one shift-add step per cycle for WIDTH cycles
// DONE   | out_valid=1; hold the result until out_ready
module alu_mc #(
  parameter int WIDTH     = 24,
  parameter int IMM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             alu_control,
  input  logic [WIDTH-1:0]       in1,
  input  logic [WIDTH-1:0]       in2,
  input  logic [IMM_WIDTH-1:0]   imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     alu_result,
  output logic [3:0]             flags,
  output logic                   err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_INV  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1100;
  localparam logic [3:0] OP_MULI = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic                 err_q, err_d;

  logic [WIDTH-1:0]     imm_ext;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     sc_res;
  logic                 sc_c;
  logic                 sc_v;
  logic                 sc_err;
  logic                 is_mul;
  logic [2*WIDTH-1:0]   prod_step;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  always_comb begin
    imm_ext = WIDTH'(imm);
    op_b    = (alu_control == OP_ADDI) ? imm_ext : in2;
    sum     = {1'b0, in1} + {1'b0, op_b};
    diff    = in1 - in2;
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_err  = 1'b0;
    is_mul  = 1'b0;
    case (alu_control)
      OP_ADD, OP_ADDI: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (in1[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_c   = (in1 < in2);
        sc_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_MUL, OP_MULI: is_mul = 1'b1;
      OP_XOR:  sc_res = in1 ^ in2;
      OP_INV:  sc_res = ~in1;
      OP_AND:  sc_res = in1 & in2;
      OP_OR:   sc_res = in1 | in2;
      OP_NOP:  sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  assign prod_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, in1};
            mplier_d = (alu_control == OP_MULI) ? imm_ext : in2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = {{WIDTH{1'b0}}, sc_res};
            flags_d  = sc_err ? 4'b0000
                              : {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
            err_d    = sc_err;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = prod_step;
          flags_d  = {prod_step[WIDTH-1], (prod_step == '0), 1'b0,
                      (prod_step[2*WIDTH-1:WIDTH] != '0)};
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held
  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign alu_result = result_q;
  assign flags      = flags_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 24-bit instance for the main sequence and an
// 8-bit instance for the narrow multiply.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  alu_control, flags;
  logic [23:0] in1, in2;
  logic [7:0]  imm;
  logic [47:0] alu_result;

  logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8, err_8;
  logic [3:0]  alu_control_8, flags_8;
  logic [7:0]  in1_8, in2_8, imm_8;
  logic [15:0] alu_result_8;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic bp_ok, seen;

  alu_mc #(.WIDTH(24), .IMM_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .in1(in1), .in2(in2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .flags(flags), .err(err)
  );

  alu_mc #(.WIDTH(8), .IMM_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .alu_control(alu_control_8), .in1(in1_8), .in2(in2_8), .imm(imm_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8), .alu_result(alu_result_8),
    .flags(flags_8), .err(err_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request, wait for acceptance, scramble inputs, return edges to out_valid
  task automatic run_op(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic [7:0] im, output int l);
    int w;
    @(negedge clk);
    alu_control = op; in1 = a; in2 = b; imm = im; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("accept_timeout", 64'(w), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in1 = 24'h5A5A5A; in2 = 24'hA5A5A5; imm = 8'h3C; alu_control = 4'b0110;
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'b0; in1 = '0; in2 = '0; imm = '0;
    in_valid_8 = 1'b0; out_ready_8 = 1'b0; alu_control_8 = 4'b0;
    in1_8 = '0; in2_8 = '0; imm_8 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(alu_result), 64'd0);
    chk("rst_flags_err", 64'({flags, err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_op(4'b0000, 24'hFFFFFF, 24'h000001, 8'h00, lat);
    chk("add_wrap_lat", 64'(lat), 64'd1);
    chk("add_wrap_res", 64'(alu_result), 64'h0);
    chk("add_wrap_flags", 64'(flags), 64'b0110);
    consume();

    run_op(4'b0000, 24'h7FFFFF, 24'h000001, 8'h00, lat);
    chk("add_ovf_res", 64'(alu_result), 64'h800000);
    chk("add_ovf_flags", 64'(flags), 64'b1001);
    consume();

    run_op(4'b0001, 24'h000005, 24'h000007, 8'h00, lat);
    chk("sub_res", 64'(alu_result), 64'hFFFFFE);
    chk("sub_flags", 64'(flags), 64'b1010);
    consume();

    run_op(4'b0100, 24'h0F0F0F, 24'h000000, 8'h00, lat);
    chk("inv_res", 64'(alu_result), 64'hF0F0F0);
    chk("inv_flags", 64'(flags), 64'b1000);
    consume();

    run_op(4'b0010, 24'hFFFFFF, 24'hFFFFFF, 8'h00, lat);
    chk("mul_lat", 64'(lat), 64'd25);
    chk("mul_res", 64'(alu_result), 64'hFFFFFE000001);
    chk("mul_flags", 64'(flags), 64'b0001);
    consume();

    run_op(4'b1101, 24'h000010, 24'hABCDEF, 8'h10, lat);
    chk("muli_lat", 64'(lat), 64'd25);
    chk("muli_res", 64'(alu_result), 64'h100);
    chk("muli_flags", 64'(flags), 64'b0000);
    consume();

    run_op(4'b0011, 24'hFF00FF, 24'h0F0F0F, 8'h00, lat);
    chk("xor_res", 64'(alu_result), 64'hF00FF0);
    chk("xor_flags", 64'(flags), 64'b1000);
    @(negedge clk);
    alu_control = 4'b0101; in1 = 24'hFFFF00; in2 = 24'h00FFFF; in_valid = 1'b1;
    bp_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || alu_result !== 48'hF00FF0 || in_ready !== 1'b0) bp_ok = 1'b0;
    end
    chk("bp_hold", 64'(bp_ok), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_pending_valid", 64'(out_valid), 64'd1);
    chk("bp_pending_res", 64'(alu_result), 64'h00FF00);
    chk("bp_pending_flags", 64'(flags), 64'b0000);
    consume();

    run_op(4'b1001, 24'h123456, 24'h654321, 8'h00, lat);
    chk("illegal_lat", 64'(lat), 64'd1);
    chk("illegal_res", 64'(alu_result), 64'h0);
    chk("illegal_flags_err", 64'({flags, err}), 64'b00001);
    consume();

    run_op(4'b1000, 24'h123456, 24'h654321, 8'h00, lat);
    chk("nop_res", 64'(alu_result), 64'h0);
    chk("nop_flags_err", 64'({flags, err}), 64'b01000);
    consume();

    run_op(4'b0110, 24'h123400, 24'h000056, 8'h00, lat);
    chk("or_res", 64'(alu_result), 64'h123456);
    consume();

    run_op(4'b1100, 24'hFFFFF0, 24'h000000, 8'h20, lat);
    chk("addi_res", 64'(alu_result), 64'h000010);
    chk("addi_flags", 64'(flags), 64'b0010);
    consume();

    // Reset while the multiply is at iteration 10
    @(negedge clk);
    alu_control = 4'b0010; in1 = 24'h000003; in2 = 24'h000005; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_state", 64'({out_valid, in_ready}), 64'b00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    chk("midrst_idle", 64'(in_ready), 64'd1);

    @(negedge clk);
    alu_control_8 = 4'b0010; in1_8 = 8'hFF; in2_8 = 8'hFF; in_valid_8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid_8 = 1'b0; in1_8 = 8'h00; in2_8 = 8'h00;
    lat = 1;
    while (!out_valid_8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w8_mul_lat", 64'(lat), 64'd9);
    chk("w8_mul_res", 64'(alu_result_8), 64'hFE01);
    chk("w8_mul_flags", 64'(flags_8), 64'b0001);
    @(negedge clk);
    out_ready_8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready_8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle datapath ALU. It executes the same 4-bit opcode set at configurable operand width, with a valid/ready handshake on both sides. Multiplies run on an iterative shift-add engine, and each result carries status flags and an error bit. It sits between the decode/register-read stage and writeback, and can stall both.

## Interface
- `WIDTH`, default 24: operand width in bits, ≥ 4.
- `IMM_WIDTH`, default 8: immediate width, ≤ `WIDTH`; zero-extended to `WIDTH`.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: block accepts a request this cycle.
- `alu_control` input, 4 bits: opcode.
- `in1`, `in2` input, `WIDTH` bits: operands A and B.
- `imm` input, `IMM_WIDTH` bits: immediate operand.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer takes the result.
- `alu_result` output, `2*WIDTH` bits: result.
- `flags` output, 4 bits: {n, z, c, v}.
- `err` output, 1 bit: the completed request had an illegal opcode.

## Operation
- Opcodes:
  - 0000 add: A+B.
  - 0001 sub: A−B.
  - 0010 mul: A×B.
  - 0011 xor.
  - 0100 inv: ~A.
  - 0101 and.
  - 0110 or.
  - 1000 nop: result 0.
  - 1100 addi: A+imm.
  - 1101 muli: A×imm.
  - All other opcodes (0111, 1001, 1010, 1011, 1110, 1111) are illegal: result 0, flags 0, `err`=1.
- Non-multiply results occupy bits [`WIDTH`-1:0]; upper half is 0. Arithmetic is modulo 2^`WIDTH`.
- Multiply is unsigned, with the full 2×`WIDTH` product. It processes one multiplier bit per cycle (LSB first) over exactly `WIDTH` iterations. There is no early termination.
- Flags:
  - n: bit `WIDTH`-1 of the result.
  - z: the whole `alu_result` is zero.
  - c: carry-out for add/addi; borrow (A<B unsigned) for sub; 0 otherwise.
  - v: signed overflow for add/addi/sub; upper product half ≠ 0 for mul/muli; 0 otherwise.
- FSM:
  - IDLE: `in_ready`=1. On accept (`in_valid` & `in_ready`), operands and opcode are captured. Mul/muli go to MUL with the iteration counter at 0. All other opcodes compute and register the result, flags and `err`, then go to DONE.
  - MUL: `in_ready`=0. One add/shift step per cycle. After iteration `WIDTH`-1, the product and flags are registered and the FSM goes to DONE.
  - DONE: `out_valid`=1. Outputs are held stable until `out_ready`=1, then the FSM goes to IDLE. `in_ready` stays 0 in DONE, so there is no overlap.
- Input changes after capture have no effect on the request in flight.
- Reset values: state IDLE, `out_valid`=0, `alu_result`=0, `flags`=0, `err`=0, counter 0. `in_ready`=0 while `rst_n`=0 and 1 from the first cycle after release.
- Reset mid-operation, in MUL or DONE, discards the request. No result is produced.

## Timing
- Single-cycle ops: accepted at edge N; `out_valid`=1 in the cycle following edge N (latency 1).
- Mul/muli: accepted at edge N; `out_valid`=1 following edge N+`WIDTH` (latency `WIDTH`+1; 25 cycles at the default).
- Handshake completes on a rising edge with `out_valid` & `out_ready`. The next request can be accepted, at the earliest, on the edge after the FSM returns to IDLE.
- Throughput is at most one op per 2 cycles (single-cycle) and one per `WIDTH`+2 cycles (mul).
- `out_ready` held low: DONE persists indefinitely with outputs stable.
- `in_valid` held high in MUL or DONE: ignored; the request stays pending upstream until `in_ready`=1.

## Test plan
- Add 0xFFFFFF + 0x000001: after 1 cycle, result 0, z=1, c=1, v=0, n=0. Then 0x7FFFFF + 1 gives 0x800000 with n=1, v=1.
- Sub 5 − 7: result 0xFFFFFE, n=1, c=1, v=0. Inv 0x0F0F0F gives 0xF0F0F0.
- Mul 0xFFFFFF × 0xFFFFFF: `out_valid` exactly 25 cycles after accept, result 0xFFFFFE000001, v=1. Muli 0x000010 × imm 0x10 gives 0x100, v=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. Result stays stable, `in_ready`=0, and a pending `in_valid` is not accepted until the cycle after `out_ready` pulses.
- Illegal opcode 1001: after 1 cycle, `err`=1, result 0, flags 0. The following nop gives `err`=0.
- Drive `rst_n`=0 at iteration 10 of a mul: the next cycle shows IDLE and `out_valid`=0, and no result appears afterwards. Rerun with `WIDTH`=8: 0xFF × 0xFF gives 0xFE01 after 9 cycles.
